// File: rtl/ui_input_capture.sv
// ui_input_capture: memory-mapped input peripheral for the board KEY and SW pins.
// Synchronises and debounces the raw pins, captures key presses and switch
// changes in sticky status registers, and serves four word-wide registers to the
// IO controller (combinational read, write-1-to-clear status).
//
// Registers (sel): 0 KDATA, 1 KSTAT (press flags, bit 8 overrun),
//                  2 SDATA, 3 SSTAT (change flags, bit 16 overrun)
//
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   key_n    raw KEY pins, 0 = pressed
//   sw       raw SW pins
//   sel      register select
//   rd_en    read strobe; rd_data is 0 when low
//   wr_en    write strobe; clears status bits set in wr_data (sel 1 / 3)
//   wr_data  write data (status clear mask)
//   rd_data  read data
//   irq      pending-key-event flag
//
// Optional feature: define UI_INPUT_IRQ_EN to drive irq from a flop holding the
// OR of the key press flags; otherwise irq is tied to 0.
module ui_input_capture #(
   parameter int unsigned DBITS           = 32,
   parameter int unsigned NKEYS           = 4,
   parameter int unsigned NSW             = 10,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_BITS        = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NKEYS-1:0] key_n,
   input  logic [NSW-1:0]   sw,
   input  logic [1:0]       sel,
   input  logic             rd_en,
   input  logic             wr_en,
   input  logic [DBITS-1:0] wr_data,
   output logic [DBITS-1:0] rd_data,
   output logic             irq
);

   localparam logic [CNT_BITS-1:0] CntMax = CNT_BITS'(DEBOUNCE_CYCLES - 1);

   logic [NKEYS-1:0] keyMeta, keySync, keyIn;
   logic [NSW-1:0]   swMeta, swSync;
   logic [CNT_BITS-1:0] preCnt;
   logic             tick;

   logic [NKEYS-1:0] keySample, keyDeb, keyDebNext, keyPress, keyFlags, keyClr;
   logic [NSW-1:0]   swSample, swDeb, swDebNext, swChange, swFlags, swClr;
   logic             keyOvr, keyOvrClr, swOvr, swOvrClr;
   logic [DBITS-1:0] kStatWord, sStatWord;

   // Two-flop synchronisers; keys idle high (released)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         keyMeta <= '1;
         keySync <= '1;
         swMeta  <= '0;
         swSync  <= '0;
      end else begin
         keyMeta <= key_n;
         keySync <= keyMeta;
         swMeta  <= sw;
         swSync  <= swMeta;
      end
   end

   assign keyIn = ~keySync;
   assign tick  = (preCnt == CntMax);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) preCnt <= '0;
      else       preCnt <= tick ? '0 : preCnt + CNT_BITS'(1);
   end

   always_comb begin
      keyDebNext = keyDeb;
      swDebNext  = swDeb;
      // A bit follows the synced level only when it matched the previous sample
      if (tick) begin
         keyDebNext = (keyDeb & (keyIn ^ keySample)) | (keyIn & ~(keyIn ^ keySample));
         swDebNext  = (swDeb & (swSync ^ swSample)) | (swSync & ~(swSync ^ swSample));
      end
      keyPress = keyDebNext & ~keyDeb;
      swChange = swDebNext ^ swDeb;

      keyClr    = '0;
      keyOvrClr = 1'b0;
      swClr     = '0;
      swOvrClr  = 1'b0;
      if (wr_en && sel == 2'd1) begin
         keyClr    = wr_data[NKEYS-1:0];
         keyOvrClr = wr_data[8];
      end
      if (wr_en && sel == 2'd3) begin
         swClr    = wr_data[NSW-1:0];
         swOvrClr = wr_data[16];
      end
   end

   // Set has priority over clear; overrun looks at the flags before clearing
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         keySample <= '0;
         keyDeb    <= '0;
         swSample  <= '0;
         swDeb     <= '0;
         keyFlags  <= '0;
         keyOvr    <= 1'b0;
         swFlags   <= '0;
         swOvr     <= 1'b0;
      end else begin
         if (tick) begin
            keySample <= keyIn;
            swSample  <= swSync;
         end
         keyDeb   <= keyDebNext;
         swDeb    <= swDebNext;
         keyFlags <= (keyFlags & ~keyClr) | keyPress;
         keyOvr   <= (keyOvr & ~keyOvrClr) | (|(keyPress & keyFlags));
         swFlags  <= (swFlags & ~swClr) | swChange;
         swOvr    <= (swOvr & ~swOvrClr) | (|(swChange & swFlags));
      end
   end

   always_comb begin
      kStatWord              = '0;
      kStatWord[NKEYS-1:0]   = keyFlags;
      kStatWord[8]           = keyOvr;
      sStatWord              = '0;
      sStatWord[NSW-1:0]     = swFlags;
      sStatWord[16]          = swOvr;

      rd_data = '0;
      if (rd_en) begin
         case (sel)
            2'd0:    rd_data = DBITS'(keyDeb);
            2'd1:    rd_data = kStatWord;
            2'd2:    rd_data = DBITS'(swDeb);
            default: rd_data = sStatWord;
         endcase
      end
   end

   // Only the status clear bits of wr_data are consumed
   logic unusedWrData;
   assign unusedWrData = ^wr_data;

`ifdef UI_INPUT_IRQ_EN
   logic irqQ;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) irqQ <= 1'b0;
      else       irqQ <= |keyFlags;
   end
   assign irq = irqQ;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_ui_input_capture.sv
// Bench for ui_input_capture: directed scenarios with literal expectations plus
// randomized pin/bus activity, all checked every cycle against a behavioural
// model built from edge counts and pin history.
module tb_ui_input_capture;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  key_n;
   logic [9:0]  sw;
   logic [1:0]  sel;
   logic        rd_en, wr_en;
   logic [31:0] wr_data, rd_data;
   logic        irq;

   always #5 clk = ~clk;

   ui_input_capture #(
      .DBITS(32), .NKEYS(4), .NSW(10), .DEBOUNCE_CYCLES(D), .CNT_BITS(20)
   ) dut (
      .clk(clk), .reset(reset), .key_n(key_n), .sw(sw), .sel(sel), .rd_en(rd_en),
      .wr_en(wr_en), .wr_data(wr_data), .rd_data(rd_data), .irq(irq)
   );

   int nCmp = 0;
   int nBad = 0;

   // Drive values applied at the next falling edge
   logic [3:0]  dKey;
   logic [9:0]  dSw;
   logic [1:0]  dSel;
   logic        dRd, dWr;
   logic [31:0] dWd;

`ifdef UI_INPUT_IRQ_EN
   localparam logic IrqOn = 1'b1;
`else
   localparam logic IrqOn = 1'b0;
`endif

   // Model state: n = rising edges since reset release
   int         n;
   logic [3:0] kHist [4];
   logic [9:0] sHist [4];
   logic [3:0] kSample, kDeb, kFlags;
   logic [9:0] sSample, sDeb, sFlags;
   logic       kOvr, sOvr, irqM;

   task automatic modelReset();
      n = 0;
      kSample = '0; kDeb = '0; kFlags = '0; kOvr = 1'b0;
      sSample = '0; sDeb = '0; sFlags = '0; sOvr = 1'b0;
      irqM = 1'b0;
   endtask

   // Pins seen by the debouncer at edge n are the ones present two edges earlier
   task automatic modelEdge();
      logic [3:0] ks, kn, press, kc;
      logic [9:0] ss, sn, chg, sc;
      logic       kco, sco;
      ks = (n < 2) ? 4'h0 : kHist[(n - 2) % 4];
      ss = (n < 2) ? 10'h0 : sHist[(n - 2) % 4];
      kn = kDeb;
      sn = sDeb;
      if (n % D == D - 1) begin
         for (int i = 0; i < 4; i++) if (ks[i] == kSample[i]) kn[i] = ks[i];
         for (int i = 0; i < 10; i++) if (ss[i] == sSample[i]) sn[i] = ss[i];
         kSample = ks;
         sSample = ss;
      end
      press = kn & ~kDeb;
      chg   = sn ^ sDeb;
      kc = '0; kco = 1'b0; sc = '0; sco = 1'b0;
      if (wr_en && sel == 2'd1) begin kc = wr_data[3:0]; kco = wr_data[8]; end
      if (wr_en && sel == 2'd3) begin sc = wr_data[9:0]; sco = wr_data[16]; end
      irqM   = IrqOn & (|kFlags);
      kOvr   = (kOvr & ~kco) | (|(press & kFlags));
      kFlags = (kFlags & ~kc) | press;
      sOvr   = (sOvr & ~sco) | (|(chg & sFlags));
      sFlags = (sFlags & ~sc) | chg;
      kDeb = kn;
      sDeb = sn;
      kHist[n % 4] = ~key_n;
      sHist[n % 4] = sw;
      n++;
   endtask

   function automatic logic [31:0] expRd(input logic [1:0] s, input logic en);
      if (!en) return 32'h0;
      case (s)
         2'd0:    return {28'h0, kDeb};
         2'd1:    return {23'h0, kOvr, 4'h0, kFlags};
         2'd2:    return {22'h0, sDeb};
         default: return {15'h0, sOvr, 6'h0, sFlags};
      endcase
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock: drive at negedge, check at negedge+1, advance the model at posedge.
   // lit: 0 none, 1 literal rd_data, 2 literal irq
   task automatic step(input int lit, input string nm, input logic [31:0] ex);
      @(negedge clk);
      key_n = ~dKey; sw = dSw; sel = dSel; rd_en = dRd; wr_en = dWr; wr_data = dWd;
      #1;
      cmp("model rd_data", rd_data, expRd(sel, rd_en));
      cmp("model irq", {31'h0, irq}, {31'h0, irqM});
      if (lit == 1) cmp(nm, rd_data, ex);
      if (lit == 2) cmp(nm, {31'h0, irq}, ex);
      @(posedge clk);
      if (!reset) modelEdge();
   endtask

   task automatic idle(input int k);
      dWr = 1'b0; dRd = 1'b1;
      repeat (k) begin
         dSel = 2'($urandom);
         step(0, "", 32'h0);
      end
   endtask

   task automatic litRd(input string nm, input logic [1:0] s, input logic [31:0] ex);
      dSel = s; dRd = 1'b1; dWr = 1'b0;
      step(1, nm, ex);
   endtask

   // Asserts reset mid-cycle, checks outputs are cleared at once, releases after a posedge
   task automatic doReset();
      reset = 1'b1;
      wr_en = 1'b0;
      modelReset();
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s); rd_en = 1'b1;
         #1;
         cmp($sformatf("reset rd sel%0d", s), rd_data, 32'h0);
         cmp("reset irq", {31'h0, irq}, 32'h0);
      end
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
   endtask

   initial begin
      bit found;
      dKey = 4'h0; dSw = '0; dSel = '0; dRd = 1'b0; dWr = 1'b0; dWd = '0;
      key_n = 4'hF; sw = '0; sel = '0; rd_en = 1'b0; wr_en = 1'b0; wr_data = '0;
      reset = 1'b1;

      // Reset state
      doReset();
      for (int s = 0; s < 4; s++) litRd($sformatf("post-reset sel%0d", s), 2'(s), 32'h0);

      // KEY0 press
      dKey = 4'h1;
      idle(10);
      litRd("KDATA key0", 2'd0, 32'h1);
      litRd("KSTAT key0", 2'd1, 32'h1);
      step(2, "irq after key0", {31'h0, IrqOn});

      // Short glitch on KEY1 must not register
      dKey = 4'h3;
      idle(3);
      dKey = 4'h1;
      idle(10);
      litRd("KDATA after glitch", 2'd0, 32'h1);
      litRd("KSTAT after glitch", 2'd1, 32'h1);

      // Release and press again: overrun, then clear
      dKey = 4'h0;
      idle(12);
      dKey = 4'h1;
      idle(12);
      litRd("KSTAT overrun", 2'd1, 32'h101);
      dSel = 2'd1; dRd = 1'b1; dWr = 1'b1; dWd = 32'h101;
      step(1, "KSTAT read during clear", 32'h101);
      litRd("KSTAT cleared", 2'd1, 32'h0);
      dRd = 1'b0;
      step(2, "irq after clear", 32'h0);

      // Switch changes with overrun
      dSw = 10'h3FF;
      idle(12);
      dSw = 10'h200;
      idle(12);
      litRd("SDATA", 2'd2, 32'h200);
      litRd("SSTAT overrun", 2'd3, 32'h103FF);

      // Clear KEY2 continuously while its press event lands: set must win
      dKey = 4'h5;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         dSel = 2'd1; dRd = 1'b1; dWr = 1'b1; dWd = 32'h4;
         step(0, "", 32'h0);
         found = kDeb[2];
      end
      dWr = 1'b0;
      if (!found) begin
         nCmp++; nBad++;
         $display("FAIL key2 press wait: got no event, expected one within 20 cycles");
      end
      litRd("KSTAT set beats clear", 2'd1, 32'h4);

      // Reset in the middle of a debounce
      dKey = 4'h0;
      dSw  = 10'h0F0;
      idle(5);
      #3 doReset();
      idle(4);

      // Randomized phase
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(39) == 0) dKey = dKey ^ (4'h1 << $urandom_range(3));
         if ($urandom_range(59) == 0) dSw = 10'($urandom);
         if ($urandom_range(149) == 0) dSw = dSw ^ (10'h1 << $urandom_range(9));
         dSel = 2'($urandom);
         dRd  = ($urandom_range(3) != 0);
         dWr  = ($urandom_range(7) == 0);
         dWd  = ($urandom_range(1) == 0) ? $urandom : 32'hFFFF_FFFF;
         step(0, "", 32'h0);
         if (i == 1500) #3 doReset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule

// File: doc/ui_input_capture.md
Name: ui_input_capture

Overview:
Memory-mapped input peripheral for the board's KEY and SW pins, the read-side counterpart of the LEDR/HEX output path.
- Synchronises and debounces the raw pins.
- Captures key-press and switch-change events in sticky status registers.
- Presents four word-wide registers to the IO controller: combinational read, write-1-to-clear.

Parameters:
DBITS, 32, data word width
NKEYS, 4, number of KEY inputs (board KEYs are active-low)
NSW, 10, number of SW inputs
DEBOUNCE_CYCLES, 500000, clk cycles between debounce samples (10 ms at 50 MHz); must be >= 1
CNT_BITS, 20, prescaler width; must hold DEBOUNCE_CYCLES-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
key_n  in  NKEYS  raw KEY pins, 0 = pressed
sw  in  NSW  raw SW pins
sel  in  2  register select: 0 KDATA, 1 KSTAT, 2 SDATA, 3 SSTAT
rd_en  in  1  read strobe from IO controller
wr_en  in  1  write strobe from IO controller
wr_data  in  DBITS  write data (status clear mask)
rd_data  out  DBITS  read data
irq  out  1  pending-key-event flag (see Optional Feature)

Behaviour:
- Reset, asynchronous, active-high. It clears all state:
  - sync flops for key_n set to 1 (released); sync flops for sw set to 0
  - prescaler = 0
  - sample and debounced registers: keys released (0), switches 0
  - KSTAT and SSTAT = 0; irq = 0
  - any in-progress debounce is discarded
- Synchroniser: two flops per input bit. Keys are inverted after synchronisation, so internally 1 = pressed.
- Prescaler:
  - counts 0..DEBOUNCE_CYCLES-1, then wraps to 0
  - tick = 1 in the cycle the count equals DEBOUNCE_CYCLES-1
  - DEBOUNCE_CYCLES = 1 gives a tick every cycle
- Debounce, on each tick and per bit:
  - sample <= synced value
  - if the synced value equals the previous sample, the debounced value <= synced value
  - a level must therefore match on two consecutive ticks
  - worst-case latency from pin change to debounced change is 2 + 2*DEBOUNCE_CYCLES cycles
- Events are detected in the cycle the debounced value updates:
  - key press event: debounced bit 0 -> 1. Key release sets nothing.
  - switch event: any change of a debounced switch bit.
- KSTAT (sel 1):
  - bits [NKEYS-1:0] sticky press flags
  - bit 8 overrun: set when a press event hits a flag that is already set
- SSTAT (sel 3):
  - bits [NSW-1:0] sticky change flags
  - bit 16 overrun, same rule as KSTAT
- KDATA (sel 0) = zero-extended debounced keys, 1 = pressed. SDATA (sel 2) = zero-extended debounced switches.
- Read:
  - rd_data = selected register, combinationally, while rd_en = 1; otherwise 0
  - reads have no side effects
  - unused bits read 0
- Write (wr_en = 1):
  - sel 1 or 3: each status bit with a 1 in wr_data clears on the next clk edge
  - writes to sel 0 or 2 are ignored
  - rd_en and wr_en together: the read returns the pre-clear value
- Simultaneous clear and new event on the same bit: set wins, so the event is never lost. Overrun is evaluated before the clear.

Optional Feature:
- Macro UI_INPUT_IRQ_EN defined:
  - irq is registered and equals OR of KSTAT[NKEYS-1:0] as seen one cycle later
  - irq deasserts the cycle after the last flag is cleared
- Macro not defined:
  - irq tied to 0
  - no extra flops

Test Plan:
1. Reset with key_n = 4'hF, sw = 0; read sel 0..3 -> rd_data = 0 for every sel; irq = 0.
2. DEBOUNCE_CYCLES = 4; drive key_n = 4'hE and hold -> KDATA = 1 within 10 cycles; KSTAT = 0x1; irq = 1 (IRQ_EN).
3. Glitch key_n[1] low for 3 cycles between ticks -> KDATA and KSTAT unchanged.
4. Press KEY0, release, press again without clearing -> KSTAT = 0x101; write 0x101 to sel 1 -> KSTAT = 0, irq = 0 next cycle.
5. sw = 10'h3FF, then sw = 10'h200 after debounce -> SDATA = 0x200; SSTAT = 0x103FF (overrun from second change on bits 0..8).
6. Clear write to sel 1 in the same cycle a KEY2 press event occurs -> KSTAT bit 2 = 1 afterwards; assert reset mid-debounce -> all outputs 0 immediately.
